serial_cmd_packer: RTL and testbench
====================================

Name: serial_cmd_packer

Overview:
- Host-side command formatter that sits directly upstream of the PMT serial master drivers.
- Accepts register-access requests (addr, PMT select, rd/wr, length) plus a write-data stream. Emits the header word, then the data words, on the shared master_wr_data/master_wr_vld bus.
- Holds off the next command until every selected driver has dropped its command-parser busy flag. Reports done or timeout per command.

Parameters:
- TCQ, 0.1, sim clock-to-q delay
- DATA_WIDTH, 32, bus word width
- NUM_SLAVE, 3, number of serial master drivers (busy inputs)
- FIFO_DEPTH, 32, write-data buffer depth in words (≥ max burst of 32)
- BUSY_RISE_WAIT, 4, cycles allowed for busy to assert after header
- CMD_TIMEOUT, 9999, cycles allowed from header to all-idle (100 us at 100 MHz)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset
- req_vld_i  in  1  request valid
- req_rdy_o  out  1  request accepted when vld&rdy
- req_addr_i  in  16  register address
- req_sel_i  in  8  PMT select bitmap; bits [NUM_SLAVE-1:0] used
- req_wr_i  in  1  1 = write, 0 = read
- req_len_i  in  5  word count minus 1
- wdata_vld_i  in  1  write-data push
- wdata_i  in  DATA_WIDTH  write data
- wdata_full_o  out  1  buffer full; a push while full is dropped
- cmd_busy_i  in  NUM_SLAVE  per-driver command-parser busy
- slave_ack_last_i  in  1  last read-back word from the selected driver
- master_wr_data_o  out  DATA_WIDTH  header/data word
- master_wr_vld_o  out  2  11 = header, 10 = data, 00 = idle
- cmd_done_o  out  1  1-cycle pulse: command completed
- cmd_timeout_o  out  1  1-cycle pulse: command aborted

Behaviour:
- Reset:
  - clk_i is the only clock; rst_i is asynchronous and active-high.
  - On reset: all outputs 0 except req_rdy_o = 0; FSM = IDLE; FIFO emptied.
- Header format: {addr[15:0], sel[7:0], cmd[7:0]}.
  - cmd[7] = req_wr_i.
  - cmd[6:5] = 0.
  - cmd[4:0] = req_len_i.
- FSM:
  - IDLE:
    - req_rdy_o = 1.
    - On vld&rdy, latch all req fields → CHECK. req_rdy_o drops the following cycle.
  - CHECK:
    - Write: stay until FIFO count ≥ len+1, then → HDR.
    - Read: → HDR next cycle.
  - HDR:
    - Drive vld = 11 with the header word for exactly 1 cycle. Clear rise counter and timeout counter.
    - Write → DATA. Read → WAIT_RISE.
  - DATA:
    - Pop FIFO every cycle; drive vld = 10 with the popped word. Words are gapless, len+1 cycles.
    - After the last word → WAIT_RISE.
  - WAIT_RISE:
    - Any selected busy bit = 1 → WAIT_IDLE.
    - Counter reaches BUSY_RISE_WAIT → ERR. This covers no selected slave and nonexistent sel bits.
  - WAIT_IDLE:
    - (cmd_busy_i & sel) == 0 → DONE.
  - DONE: cmd_done_o = 1 for 1 cycle → IDLE.
  - ERR:
    - cmd_timeout_o = 1 for 1 cycle.
    - For writes, discard the remaining FIFO words of this command: pop len+1 minus words already popped.
    - → IDLE.
- Timeout counter:
  - Runs from HDR through WAIT_IDLE and saturates at CMD_TIMEOUT.
  - Reaching CMD_TIMEOUT in any of those states → ERR. This has priority over a normal transition in the same cycle.
- Bus outputs: master_wr_vld_o = 00 in every state other than HDR/DATA; master_wr_data_o holds its last value.
- FIFO:
  - Synchronous, first-word-fall-through, count width clog2(FIFO_DEPTH)+1.
  - Simultaneous push and pop is allowed with full=1: the pop frees a slot first, so the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH.
- Read requests never touch the FIFO.
- A reset mid-command aborts immediately. No done/timeout pulse is emitted.

Optional Feature:
- SERIAL_CMD_PACKER_RDBACK_EN
  - Defined: for reads, WAIT_IDLE also requires slave_ack_last_i to have been seen (sticky flag, cleared in HDR) before → DONE. The timeout still applies.
  - Undefined: slave_ack_last_i is ignored; reads complete on busy fall.

Decomposition:
- Package serial_pkg holds:
  - Header field offsets (ADDR_LSB = 16, SEL_LSB = 8, CMD_RW_BIT = 7, CMD_LEN_MSB = 4).
  - VLD_HDR = 2'b11 and VLD_DATA = 2'b10.
  - FSM state encoding.
- Sub-module serial_wdata_fifo: parameterised sync FWFT FIFO with count output.

Test Plan:
- Write, addr 0x4000, sel 0x01, len 1, FIFO preloaded 0x01234567, 0x89ABCDEF; busy[0] high 3..20 cycles after header → header 0x40000181 with vld 11, then both words with vld 10 on consecutive cycles, then cmd_done_o pulse 1 cycle after busy[0] falls.
- Read, addr 0x000C, sel 0x06, len 0; busy[1] falls before busy[2] → header 0x000C0600; done only after both bits low. With RDBACK_EN, done waits for slave_ack_last_i.
- Write len 3 with only 2 words buffered → no header until the 4th push, then gapless burst.
- sel 0x04 with busy never asserting → cmd_timeout_o exactly BUSY_RISE_WAIT cycles after WAIT_RISE entry; FIFO count returns to 0; next request accepted.
- Busy stuck high → cmd_timeout_o at CMD_TIMEOUT; push 33 words into an empty FIFO → 33rd dropped, wdata_full_o = 1.
- Assert rst_i during DATA → outputs 0 asynchronously, FIFO empty, no done/timeout pulse.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants for the serial command packer: header field layout, bus
// valid codes, FSM state encoding and the header builder.
package serial_pkg;

  localparam int unsigned ADDR_LSB    = 16;
  localparam int unsigned SEL_LSB     = 8;
  localparam int unsigned CMD_RW_BIT  = 7;
  localparam int unsigned CMD_LEN_MSB = 4;

  localparam logic [1:0] VLD_IDLE = 2'b00;
  localparam logic [1:0] VLD_HDR  = 2'b11;
  localparam logic [1:0] VLD_DATA = 2'b10;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StCheck    = 3'd1;
  localparam logic [2:0] StHdr      = 3'd2;
  localparam logic [2:0] StData     = 3'd3;
  localparam logic [2:0] StWaitRise = 3'd4;
  localparam logic [2:0] StWaitIdle = 3'd5;
  localparam logic [2:0] StDone     = 3'd6;
  localparam logic [2:0] StErr      = 3'd7;

  function automatic logic [31:0] build_hdr(input logic [15:0] addr, input logic [7:0] sel,
                                            input logic wr, input logic [4:0] len);
    logic [31:0] hdr;
    hdr = '0;
    hdr[ADDR_LSB +: 16]  = addr;
    hdr[SEL_LSB +: 8]    = sel;
    hdr[CMD_RW_BIT]      = wr;
    hdr[CMD_LEN_MSB:0]   = len;
    return hdr;
  endfunction

endpackage

// File: rtl/serial_wdata_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a
// multi-word pop (used to discard the rest of an aborted write burst).
module serial_wdata_fifo
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 32,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [CW-1:0]         pop_n_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok;

  function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] ptr, input logic [CW-1:0] n);
    logic [CW:0] sum;
    sum = {2'b00, ptr} + {1'b0, n};
    if (sum >= (CW + 1)'(DEPTH)) sum = sum - (CW + 1)'(DEPTH);
    return sum[AW-1:0];
  endfunction

  always_comb begin
    // Popped words free their slots first, so a push while full still lands.
    push_ok  = push_i && ((count_q - pop_n_i) < CW'(DEPTH));
    wr_ptr_d = push_ok ? ptr_add(wr_ptr_q, CW'(1)) : wr_ptr_q;
    rd_ptr_d = ptr_add(rd_ptr_q, pop_n_i);
    count_d  = count_q + CW'(push_ok) - pop_n_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/serial_cmd_packer.sv
// Formats register-access commands (header + write burst) for the serial master
// drivers and tracks driver busy. SERIAL_CMD_PACKER_RDBACK_EN: reads also wait for slave_ack_last_i.
module serial_cmd_packer
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVE      = 3,
  parameter int unsigned FIFO_DEPTH     = 32,
  parameter int unsigned BUSY_RISE_WAIT = 4,
  parameter int unsigned CMD_TIMEOUT    = 9999
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_vld_i,
  output logic                  req_rdy_o,
  input  logic [15:0]           req_addr_i,
  input  logic [7:0]            req_sel_i,
  input  logic                  req_wr_i,
  input  logic [4:0]            req_len_i,
  input  logic                  wdata_vld_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  wdata_full_o,
  input  logic [NUM_SLAVE-1:0]  cmd_busy_i,
  input  logic                  slave_ack_last_i,
  output logic [DATA_WIDTH-1:0] master_wr_data_o,
  output logic [1:0]            master_wr_vld_o,
  output logic                  cmd_done_o,
  output logic                  cmd_timeout_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RW = $clog2(BUSY_RISE_WAIT + 1);
  localparam int unsigned TW = $clog2(CMD_TIMEOUT + 1);

  logic [2:0]            state_q, state_d;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            sel_q, sel_d;
  logic                  wr_q, wr_d;
  logic [4:0]            len_q, len_d;
  logic [5:0]            word_cnt_q, word_cnt_d;
  logic [RW-1:0]         rise_q, rise_d;
  logic [TW-1:0]         to_q, to_d, to_next;
  logic                  rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         pop_n, fifo_count;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [5:0]            need_words;
  logic                  busy_sel, timeout_hit, rise_expired, rd_ok;

  serial_wdata_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (wdata_vld_i),
    .wdata_i(wdata_i),
    .pop_n_i(pop_n),
    .rdata_o(fifo_rdata),
    .count_o(fifo_count),
    .full_o (wdata_full_o)
  );

  assign need_words   = {1'b0, len_q} + 6'd1;
  assign busy_sel     = |(cmd_busy_i & sel_q[NUM_SLAVE-1:0]);
  assign timeout_hit  = (to_q == TW'(CMD_TIMEOUT));
  assign to_next      = timeout_hit ? to_q : to_q + TW'(1);
  assign rise_expired = (rise_q == RW'(BUSY_RISE_WAIT - 1));

`ifdef SERIAL_CMD_PACKER_RDBACK_EN
  logic ack_seen_q, ack_seen_d;
  assign ack_seen_d = (state_q == StHdr) ? 1'b0 : (ack_seen_q | slave_ack_last_i);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ack_seen_q <= 1'b0;
    else       ack_seen_q <= ack_seen_d;
  end
  assign rd_ok = wr_q | ack_seen_q | slave_ack_last_i;
`else
  logic unused_ack;
  assign unused_ack = slave_ack_last_i;
  assign rd_ok      = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wr_d       = wr_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    rise_d     = rise_q;
    to_d       = to_q;
    pop_n      = '0;
    unique case (state_q)
      StIdle: begin
        if (req_vld_i && rdy_q) begin
          addr_d  = req_addr_i;
          sel_d   = req_sel_i;
          wr_d    = req_wr_i;
          len_d   = req_len_i;
          state_d = StCheck;
        end
      end
      StCheck: if (!wr_q || fifo_count >= CW'(need_words)) state_d = StHdr;
      StHdr: begin
        word_cnt_d = '0;
        rise_d     = '0;
        to_d       = TW'(1);
        state_d    = wr_q ? StData : StWaitRise;
      end
      StData: begin
        pop_n      = CW'(1);
        word_cnt_d = word_cnt_q + 6'd1;
        to_d       = to_next;
        if (timeout_hit)                        state_d = StErr;
        else if (word_cnt_q == {1'b0, len_q})   state_d = StWaitRise;
      end
      StWaitRise: begin
        rise_d = rise_q + RW'(1);
        to_d   = to_next;
        if (timeout_hit)       state_d = StErr;
        else if (busy_sel)     state_d = StWaitIdle;
        else if (rise_expired) state_d = StErr;
      end
      StWaitIdle: begin
        to_d = to_next;
        if (timeout_hit)              state_d = StErr;
        else if (!busy_sel && rd_ok)  state_d = StDone;
      end
      StDone: state_d = StIdle;
      StErr: begin
        // Drop whatever part of this write burst was never sent.
        if (wr_q) pop_n = CW'(need_words - word_cnt_q);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rdy_d = (state_d == StIdle);

  always_comb begin
    master_wr_vld_o  = VLD_IDLE;
    master_wr_data_o = data_q;
    case (state_q)
      StHdr: begin
        master_wr_vld_o  = VLD_HDR;
        master_wr_data_o = DATA_WIDTH'(build_hdr(addr_q, sel_q, wr_q, len_q));
      end
      StData: begin
        master_wr_vld_o  = VLD_DATA;
        master_wr_data_o = fifo_rdata;
      end
      default: ;
    endcase
  end

  assign req_rdy_o     = rdy_q;
  assign cmd_done_o    = (state_q == StDone);
  assign cmd_timeout_o = (state_q == StErr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      sel_q      <= '0;
      wr_q       <= 1'b0;
      len_q      <= '0;
      word_cnt_q <= '0;
      rise_q     <= '0;
      to_q       <= '0;
      rdy_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wr_q       <= wr_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      rise_q     <= rise_d;
      to_q       <= to_d;
      rdy_q      <= rdy_d;
      data_q     <= master_wr_data_o;
    end
  end

endmodule

// File: tb/tb_serial_cmd_packer.sv
// Directed self-checking bench for serial_cmd_packer: write/read commands,
// buffer hold-off, busy-rise and command timeouts, FIFO full and mid-burst reset.
module tb_serial_cmd_packer;

  localparam int unsigned CTO = 9999;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_vld_i;
  logic        req_rdy_o;
  logic [15:0] req_addr_i;
  logic [7:0]  req_sel_i;
  logic        req_wr_i;
  logic [4:0]  req_len_i;
  logic        wdata_vld_i;
  logic [31:0] wdata_i;
  logic        wdata_full_o;
  logic [2:0]  cmd_busy_i;
  logic        slave_ack_last_i;
  logic [31:0] master_wr_data_o;
  logic [1:0]  master_wr_vld_o;
  logic        cmd_done_o;
  logic        cmd_timeout_o;

  int n_tests = 0;
  int n_fail  = 0;

  serial_cmd_packer #(
    .DATA_WIDTH    (32),
    .NUM_SLAVE     (3),
    .FIFO_DEPTH    (32),
    .BUSY_RISE_WAIT(4),
    .CMD_TIMEOUT   (CTO)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_vld_i       (req_vld_i),
    .req_rdy_o       (req_rdy_o),
    .req_addr_i      (req_addr_i),
    .req_sel_i       (req_sel_i),
    .req_wr_i        (req_wr_i),
    .req_len_i       (req_len_i),
    .wdata_vld_i     (wdata_vld_i),
    .wdata_i         (wdata_i),
    .wdata_full_o    (wdata_full_o),
    .cmd_busy_i      (cmd_busy_i),
    .slave_ack_last_i(slave_ack_last_i),
    .master_wr_data_o(master_wr_data_o),
    .master_wr_vld_o (master_wr_vld_o),
    .cmd_done_o      (cmd_done_o),
    .cmd_timeout_o   (cmd_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d failed=%0d)", n_tests, n_fail);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    wdata_vld_i = 1'b1;
    wdata_i     = w;
    step();
    wdata_vld_i = 1'b0;
  endtask

  task automatic send_req(input logic [15:0] a, input logic [7:0] s, input logic w,
                          input logic [4:0] l);
    int k = 0;
    while (!req_rdy_o && k < 50) begin
      step();
      k++;
    end
    req_vld_i  = 1'b1;
    req_addr_i = a;
    req_sel_i  = s;
    req_wr_i   = w;
    req_len_i  = l;
    step();
    req_vld_i  = 1'b0;
  endtask

  task automatic wait_hdr();
    int k = 0;
    while (master_wr_vld_o !== 2'b11 && k < 20) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_vld_i = 1'b0; req_addr_i = '0; req_sel_i = '0; req_wr_i = 1'b0; req_len_i = '0;
    wdata_vld_i = 1'b0; wdata_i = '0; cmd_busy_i = '0; slave_ack_last_i = 1'b0;
    step();
    step();
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o, cmd_done_o, cmd_timeout_o} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: vld=%b data=%h done=%b to=%b want all 0",
               master_wr_vld_o, master_wr_data_o, cmd_done_o, cmd_timeout_o);
    end
    n_tests++;
    if (req_rdy_o !== 1'b0 || wdata_full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy_full: rdy=%b full=%b want 0 0", req_rdy_o, wdata_full_o);
    end
    rst_i = 1'b0;
    step();
    n_tests++;
    if (req_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_after_reset: got %b want 1", req_rdy_o);
    end
  endtask

  task automatic test_write_basic();
    int done_at = -1;
    int n_done = 0;
    int n_to = 0;
    push_word(32'h0123_4567);
    push_word(32'h89AB_CDEF);
    send_req(16'h4000, 8'h01, 1'b1, 5'd1);
    wait_hdr();
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o} !== {2'b11, 32'h4000_0181}) begin
      n_fail++;
      $display("FAIL wr_header: got %b/%h want 11/40000181", master_wr_vld_o, master_wr_data_o);
    end
    step();
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o} !== {2'b10, 32'h0123_4567}) begin
      n_fail++;
      $display("FAIL wr_data0: got %b/%h want 10/01234567", master_wr_vld_o, master_wr_data_o);
    end
    step();
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o} !== {2'b10, 32'h89AB_CDEF}) begin
      n_fail++;
      $display("FAIL wr_data1: got %b/%h want 10/89abcdef", master_wr_vld_o, master_wr_data_o);
    end
    for (int r = 3; r <= 30; r++) begin
      step();
      cmd_busy_i = (r >= 3 && r <= 20) ? 3'b001 : 3'b000;
      if (cmd_done_o) begin
        n_done++;
        done_at = r;
      end
      if (cmd_timeout_o) n_to++;
    end
    n_tests++;
    if (n_done != 1 || done_at != 22 || n_to != 0) begin
      n_fail++;
      $display("FAIL wr_done: pulses=%0d at=%0d timeouts=%0d want 1 at 22, 0 timeouts",
               n_done, done_at, n_to);
    end
    n_tests++;
    if (req_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_rdy_back: got %b want 1", req_rdy_o);
    end
  endtask

  task automatic test_read();
    int done_at = -1;
    int n_done = 0;
    int n_vld = 0;
`ifdef SERIAL_CMD_PACKER_RDBACK_EN
    int exp_done = 15;
`else
    int exp_done = 11;
`endif
    send_req(16'h000C, 8'h06, 1'b0, 5'd0);
    wait_hdr();
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o} !== {2'b11, 32'h000C_0600}) begin
      n_fail++;
      $display("FAIL rd_header: got %b/%h want 11/000c0600", master_wr_vld_o, master_wr_data_o);
    end
    for (int r = 1; r <= 30; r++) begin
      step();
      cmd_busy_i       = {(r <= 9), (r <= 5), 1'b0};
      slave_ack_last_i = (r == 14);
      if (cmd_done_o) begin
        n_done++;
        done_at = r;
      end
      if (master_wr_vld_o != 2'b00) n_vld++;
    end
    cmd_busy_i       = '0;
    slave_ack_last_i = 1'b0;
    n_tests++;
    if (n_done != 1 || done_at != exp_done) begin
      n_fail++;
      $display("FAIL rd_done: pulses=%0d at=%0d want 1 at %0d", n_done, done_at, exp_done);
    end
    n_tests++;
    if (n_vld != 0) begin
      n_fail++;
      $display("FAIL rd_bus_idle: %0d non-idle cycles want 0", n_vld);
    end
  endtask

  task automatic test_len_wait();
    logic [31:0] exp_w [4];
    int n_hdr = 0;
    int done_at = -1;
    exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222;
    exp_w[2] = 32'h3333_3333; exp_w[3] = 32'h4444_4444;
    push_word(exp_w[0]);
    push_word(exp_w[1]);
    send_req(16'h1234, 8'h01, 1'b1, 5'd3);
    for (int i = 0; i < 6; i++) begin
      step();
      if (master_wr_vld_o != 2'b00) n_hdr++;
    end
    push_word(exp_w[2]);
    if (master_wr_vld_o != 2'b00) n_hdr++;
    n_tests++;
    if (n_hdr != 0) begin
      n_fail++;
      $display("FAIL len_holdoff: %0d bus cycles before 4th push want 0", n_hdr);
    end
    push_word(exp_w[3]);
    wait_hdr();
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o} !== {2'b11, 32'h1234_0183}) begin
      n_fail++;
      $display("FAIL len_header: got %b/%h want 11/12340183", master_wr_vld_o, master_wr_data_o);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({master_wr_vld_o, master_wr_data_o} !== {2'b10, exp_w[i]}) begin
        n_fail++;
        $display("FAIL len_burst%0d: got %b/%h want 10/%h", i, master_wr_vld_o,
                 master_wr_data_o, exp_w[i]);
      end
    end
    for (int r = 5; r <= 20; r++) begin
      step();
      cmd_busy_i = (r >= 5 && r <= 7) ? 3'b001 : 3'b000;
      if (cmd_done_o) done_at = r;
    end
    n_tests++;
    if (done_at != 9) begin
      n_fail++;
      $display("FAIL len_done: at=%0d want 9", done_at);
    end
  endtask

  task automatic test_rise_timeout();
    int to_at = -1;
    int n_to = 0;
    int n_done = 0;
    push_word(32'hDEAD_BEEF);
    send_req(16'h0010, 8'h04, 1'b1, 5'd0);
    wait_hdr();
    for (int r = 1; r <= 12; r++) begin
      step();
      if (cmd_timeout_o) begin
        n_to++;
        to_at = r;
      end
      if (cmd_done_o) n_done++;
    end
    n_tests++;
    if (n_to != 1 || to_at != 6 || n_done != 0) begin
      n_fail++;
      $display("FAIL rise_to_wr: pulses=%0d at=%0d done=%0d want 1 at 6, 0 done",
               n_to, to_at, n_done);
    end
    n_tests++;
    if (dut.u_fifo.count_o !== 6'd0) begin
      n_fail++;
      $display("FAIL rise_to_fifo: count=%0d want 0", dut.u_fifo.count_o);
    end
    to_at = -1;
    send_req(16'h0020, 8'h08, 1'b0, 5'd0);
    wait_hdr();
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o} !== {2'b11, 32'h0020_0800}) begin
      n_fail++;
      $display("FAIL rise_to_rd_hdr: got %b/%h want 11/00200800", master_wr_vld_o,
               master_wr_data_o);
    end
    for (int r = 1; r <= 10; r++) begin
      step();
      if (cmd_timeout_o) to_at = r;
    end
    n_tests++;
    if (to_at != 5) begin
      n_fail++;
      $display("FAIL rise_to_rd: at=%0d want 5", to_at);
    end
  endtask

  task automatic test_cmd_timeout_and_full();
    int to_at = -1;
    int bad_i = -1;
    logic [31:0] bad_got;
    int n_done = 0;
    send_req(16'h0030, 8'h01, 1'b0, 5'd0);
    cmd_busy_i = 3'b001;
    wait_hdr();
    for (int r = 1; r <= CTO + 100; r++) begin
      step();
      if (cmd_timeout_o && to_at < 0) to_at = r;
      if (cmd_done_o) n_done++;
      if (to_at >= 0 && r > to_at + 2) break;
    end
    cmd_busy_i = '0;
    n_tests++;
    if (to_at != CTO + 1 || n_done != 0) begin
      n_fail++;
      $display("FAIL cmd_timeout: at=%0d done=%0d want %0d, 0 done", to_at, n_done, CTO + 1);
    end
    for (int i = 0; i < 32; i++) push_word(32'h5000_0000 + i);
    n_tests++;
    if (wdata_full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_at_32: got %b want 1", wdata_full_o);
    end
    push_word(32'hBAD0_0033);
    n_tests++;
    if (wdata_full_o !== 1'b1 || dut.u_fifo.count_o !== 6'd32) begin
      n_fail++;
      $display("FAIL push_33_dropped: full=%b count=%0d want 1 32", wdata_full_o,
               dut.u_fifo.count_o);
    end
    send_req(16'h0040, 8'h01, 1'b1, 5'd31);
    wait_hdr();
    for (int i = 0; i < 32; i++) begin
      step();
      wdata_vld_i = (i == 0);
      wdata_i     = 32'hA5A5_A5A5;
      if (bad_i < 0 && {master_wr_vld_o, master_wr_data_o} !== {2'b10, 32'h5000_0000 + i}) begin
        bad_i   = i;
        bad_got = master_wr_data_o;
      end
    end
    wdata_vld_i = 1'b0;
    n_tests++;
    if (bad_i >= 0) begin
      n_fail++;
      $display("FAIL full_burst: word %0d got %h want %h", bad_i, bad_got,
               32'h5000_0000 + bad_i);
    end
    for (int r = 33; r <= 45; r++) begin
      step();
      cmd_busy_i = (r == 33 || r == 34) ? 3'b001 : 3'b000;
      if (cmd_done_o) n_done++;
    end
    n_tests++;
    if (n_done != 1 || dut.u_fifo.count_o !== 6'd1) begin
      n_fail++;
      $display("FAIL full_push_pop: done=%0d count=%0d want 1 1", n_done, dut.u_fifo.count_o);
    end
  endtask

  task automatic test_reset_mid();
    int n_pulse = 0;
    push_word(32'h7777_7777);
    push_word(32'h8888_8888);
    send_req(16'h0050, 8'h01, 1'b1, 5'd1);
    wait_hdr();
    step();
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o} !== {2'b10, 32'hA5A5_A5A5}) begin
      n_fail++;
      $display("FAIL mid_first_word: got %b/%h want 10/a5a5a5a5", master_wr_vld_o,
               master_wr_data_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    n_tests++;
    if ({master_wr_vld_o, master_wr_data_o, req_rdy_o, cmd_done_o, cmd_timeout_o} !== 37'd0 ||
        dut.u_fifo.count_o !== 6'd0) begin
      n_fail++;
      $display("FAIL mid_async_reset: vld=%b data=%h rdy=%b count=%0d want all 0",
               master_wr_vld_o, master_wr_data_o, req_rdy_o, dut.u_fifo.count_o);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 2) rst_i = 1'b0;
      if (cmd_done_o || cmd_timeout_o) n_pulse++;
    end
    n_tests++;
    if (n_pulse != 0 || req_rdy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after_reset: pulses=%0d rdy=%b want 0 1", n_pulse, req_rdy_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read();
    test_len_wait();
    test_rise_timeout();
    test_cmd_timeout_and_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
